// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: shares the byte-wide SDRAM port among LD, CART and SPCH.
// Optional ARB_TIMEOUT_EN adds a WAIT watchdog that fills 8'hFF and sets err.
module sdram_client_arbiter #(
  parameter int AW         = 25,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ack,
  input  logic          cart_req,
  input  logic [AW-1:0] cart_addr,
  output logic [7:0]    cart_data,
  output logic          cart_ack,
  input  logic          sp_req,
  input  logic [AW-1:0] sp_addr,
  output logic [7:0]    sp_data,
  output logic          sp_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_rd,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic          busy,
  output logic          err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("sdram_client_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_LD,
    OWN_CART,
    OWN_SPCH
  } owner_t;

  state_t        state;
  state_t        state_nx;
  owner_t        owner;
  owner_t        win;
  logic          any_req;
  logic          sp_first;
  logic          grant;
  logic          finish;
  logic          timed_out;
  logic [7:0]    fill;
  logic [3:0]    starve;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q;

  assign any_req  = ld_req | cart_req | sp_req;
  assign sp_first = sp_req && (starve == 4'(STARVE_MAX));
  assign grant    = (state == S_IDLE) && any_req;
  assign finish   = (state == S_WAIT) && (mem_ready || timed_out);
  assign fill     = timed_out ? 8'hFF : mem_dout;
  assign busy     = (state != S_IDLE);
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

  // pick the winner: LD first, then CART unless SPCH has starved out
  always_comb begin
    win = OWN_SPCH;
    if (ld_req)
      win = OWN_LD;
    else if (cart_req && !sp_first)
      win = OWN_CART;
  end

  // state register
  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // next state, strobes and acks
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_rd   = 1'b0;
    ld_ack   = 1'b0;
    cart_ack = 1'b0;
    sp_ack   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        mem_we   = (owner == OWN_LD);
        mem_rd   = (owner != OWN_LD);
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready || timed_out)
          state_nx = S_DONE;
      end
      S_DONE: begin
        ld_ack   = (owner == OWN_LD);
        cart_ack = (owner == OWN_CART);
        sp_ack   = (owner == OWN_SPCH);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // latch owner, address and write byte when a request is granted
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner  <= OWN_LD;
      addr_q <= '0;
      din_q  <= '0;
    end else if (grant) begin
      owner <= win;
      unique case (win)
        OWN_LD: begin
          addr_q <= ld_addr;
          din_q  <= ld_data;
        end
        OWN_CART: addr_q <= cart_addr;
        default:  addr_q <= sp_addr;
      endcase
    end
  end

  // count CART grants made while SPCH waits; SPCH grant or idle SPCH clears
  always_ff @(posedge clk_sys) begin
    if (reset)
      starve <= '0;
    else if (state == S_IDLE) begin
      if (!sp_req)
        starve <= '0;
      else if (any_req && win == OWN_SPCH)
        starve <= '0;
      else if (any_req && win == OWN_CART &&
               starve != 4'(STARVE_MAX))
        starve <= starve + 4'd1;
    end
  end

  // per-client read data holding registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cart_data <= '0;
      sp_data   <= '0;
    end else if (finish) begin
      if (owner == OWN_CART)
        cart_data <= fill;
      else if (owner == OWN_SPCH)
        sp_data <= fill;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timed_out = (state == S_WAIT) && !mem_ready &&
                     (wait_cnt == 8'(TIMEOUT - 1));

  // cycles spent in WAIT for the current command
  always_ff @(posedge clk_sys) begin
    if (reset || state != S_WAIT)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 8'd1;
  end

  // sticky timeout flag
  always_ff @(posedge clk_sys) begin
    if (reset)
      err <= 1'b0;
    else if (timed_out)
      err <= 1'b1;
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
